// File: rtl/nisc_pkg.sv
// Shared definitions for the NISC register file arbiter.
package nisc_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Width of the lock burst counter, which must hold values up to max_burst.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set req bit at or above ptr,
// wrapping modulo NREQ, is returned as a one-hot grant and as an index.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W:0]   pos_wide;
  logic [PTR_W-1:0] pos;

  // Walk the requesters starting at ptr and keep the first active one.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    pos_wide = '0;
    pos      = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos_wide = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (pos_wide >= (PTR_W + 1)'(NREQ)) begin
        pos_wide = pos_wide - (PTR_W + 1)'(NREQ);
      end
      pos = pos_wide[PTR_W-1:0];
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/regs_arbiter.sv
// Round-robin arbiter with bounded locking in front of the single-port
// NISC register file. Grants are combinational; read valid is registered.
module regs_arbiter
  import nisc_pkg::*;
#(
  parameter int N         = 8,
  parameter int RSIZE     = 1,
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*RSIZE-1:0] addr,
  input  logic [NREQ*N-1:0]     wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [N-1:0]          rdata,
  output logic                  rf_w,
  output logic [RSIZE-1:0]      rf_addr,
  output logic [N-1:0]          rf_wdata,
  input  logic [N-1:0]          rf_rdata
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = cnt_width(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  rvalid_q, rvalid_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic [PTR_W-1:0] sel_idx;

  logic [RSIZE-1:0] addr_a  [NREQ];
  logic [N-1:0]     wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*RSIZE +: RSIZE];
    assign wdata_a[g] = wdata[g*N +: N];
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NREQ - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state, grant and register file port logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt      = '0;
    sel_idx  = '0;
    rf_w     = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    rvalid_d = '0;

    if (!reset) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt     = pick_gnt;
            sel_idx = pick_idx;
            ptr_d   = next_ptr(pick_idx);
            // A burst of one cycle is just the granting cycle, so no lock.
            if (lock[pick_idx] && (MAX_BURST > 1)) begin
              state_d = ARB_LOCKED;
              owner_d = pick_idx;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ARB_LOCKED: begin
          gnt[owner_q] = req[owner_q];
          sel_idx      = owner_q;
          // cnt counts cycles already held; this cycle is number cnt+1, so
          // the owner is released once this cycle brings it to MAX_BURST.
          if (!lock[owner_q] || (cnt_q >= CNT_W'(MAX_BURST - 1))) begin
            state_d = ARB_IDLE;
            ptr_d   = next_ptr(owner_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ARB_IDLE;
      endcase

      if (|gnt) begin
        rf_w     = we[sel_idx];
        rf_addr  = addr_a[sel_idx];
        rf_wdata = wdata_a[sel_idx];
      end
      rvalid_d = gnt & ~we;
    end
  end

  // State, pointer, lock counter and read-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  // A read completing while reset is asserted is discarded, not reported.
  assign rvalid = rvalid_q & {NREQ{~reset}};
  assign rdata  = rf_rdata;

endmodule

// File: tb/tb_regs_arbiter.sv
// Bench for regs_arbiter paired with a small two-entry register file model.
module tb_regs_arbiter;

  localparam int N = 8, RSIZE = 1, NREQ = 2, MAX_BURST = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req, lock, we;
  logic [NREQ*RSIZE-1:0] addr;
  logic [NREQ*N-1:0]     wdata;
  logic [NREQ-1:0]       gnt, rvalid;
  logic [N-1:0]          rdata, rf_wdata, rf_rdata;
  logic                  rf_w;
  logic [RSIZE-1:0]      rf_addr;

  regs_arbiter #(.N(N), .RSIZE(RSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rf_w(rf_w),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read returning the pre-write content.
  logic [N-1:0] regs [2**RSIZE];
  initial for (int i = 0; i < 2**RSIZE; i++) regs[i] = '0;
  always @(posedge clk) begin
    rf_rdata <= regs[rf_addr];
    if (rf_w) regs[rf_addr] <= rf_wdata;
  end

  typedef struct {
    logic       rst;
    logic [1:0] req, lock, we;
    logic       a0, a1;
    logic [7:0] wd0, wd1;
    logic [1:0] exp_gnt;
  } vec_t;

  typedef struct {
    logic [1:0] mask;
    logic [7:0] data;
  } rd_t;

  vec_t vecs[$];
  rd_t  sb[$];
  logic [7:0] shadow [2];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] rq, input logic [1:0] lk,
                     input logic [1:0] w, input logic a0, input logic a1,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] eg);
    vec_t v;
    v.rst = rst; v.req = rq; v.lock = lk; v.we = w; v.a0 = a0; v.a1 = a1;
    v.wd0 = d0; v.wd1 = d1; v.exp_gnt = eg;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; req = v.req; lock = v.lock; we = v.we;
    addr  = {v.a1, v.a0};
    wdata = {v.wd1, v.wd0};
  endtask

  initial begin
    vec_t v;
    rd_t  e, pend;
    logic       ew;
    logic       ea;
    logic [7:0] ed;
    int run, seen0;

    shadow[0] = '0; shadow[1] = '0;
    // rst req lock we a0 a1 wd0 wd1 gnt
    add(1, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00);
    // write r1 then read it back
    add(0, 2'b01, 2'b00, 2'b01, 1, 0, 8'h5A, 8'h00, 2'b01);
    add(0, 2'b01, 2'b00, 2'b00, 1, 0, 8'h00, 8'h00, 2'b01);
    add(0, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00);
    // plain alternation after reset
    add(1, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00);
    add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10);
    add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10);
    // requester 1 locks for ten cycles: bursts capped at four grants
    add(0, 2'b11, 2'b10, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 2'b10, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10);
    add(0, 2'b11, 2'b10, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 2'b10, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10);
    add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    // requester 0 locks then goes idle: nobody else is served
    add(0, 2'b01, 2'b01, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    add(0, 2'b10, 2'b01, 2'b00, 0, 1, 8'h00, 8'h00, 2'b00);
    add(0, 2'b10, 2'b01, 2'b00, 0, 1, 8'h00, 8'h00, 2'b00);
    add(0, 2'b10, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b00);
    add(0, 2'b10, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10);
    // reset right after a granted read
    add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    add(1, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b00);
    add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    add(0, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00);
    // writes from both requesters, then reads
    add(0, 2'b01, 2'b00, 2'b01, 0, 0, 8'h11, 8'h00, 2'b01);
    add(0, 2'b10, 2'b00, 2'b10, 0, 1, 8'h00, 8'h22, 2'b10);
    add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    add(0, 2'b10, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10);
    add(0, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00);
    // contending writes: both land
    add(0, 2'b11, 2'b00, 2'b11, 0, 1, 8'h33, 8'h44, 2'b01);
    add(0, 2'b10, 2'b00, 2'b10, 0, 1, 8'h00, 8'h44, 2'b10);
    add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01);
    add(0, 2'b10, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10);
    add(0, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00);

    e.mask = 2'b00; e.data = 8'h00;
    sb.push_back(e);

    foreach (vecs[k]) begin
      v = vecs[k];
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      check($sformatf("gnt[%0d]", k), 32'(gnt), 32'(v.exp_gnt));
      ew = 1'b0; ea = 1'b0; ed = 8'h00;
      if (v.exp_gnt == 2'b01) begin ew = v.we[0]; ea = v.a0; ed = v.wd0; end
      if (v.exp_gnt == 2'b10) begin ew = v.we[1]; ea = v.a1; ed = v.wd1; end
      check($sformatf("rf_w[%0d]", k), 32'(rf_w), 32'(ew));
      check($sformatf("rf_addr[%0d]", k), 32'(rf_addr), 32'(ea));
      check($sformatf("rf_wdata[%0d]", k), 32'(rf_wdata), 32'(ed));

      pend = sb.pop_front();
      if (v.rst) pend.mask = 2'b00;
      check($sformatf("rvalid[%0d]", k), 32'(rvalid), 32'(pend.mask));
      if (pend.mask != 2'b00) check($sformatf("rdata[%0d]", k), 32'(rdata), 32'(pend.data));

      e.mask = 2'b00; e.data = 8'h00;
      if (!v.rst && v.exp_gnt != 2'b00 && !ew) begin
        e.mask = v.exp_gnt;
        e.data = shadow[ea];
      end
      sb.push_back(e);
      if (!v.rst && v.exp_gnt != 2'b00 && ew) shadow[ea] = ed;
    end

    // Long contention with a permanent lock on requester 1.
    @(posedge clk); #1;
    reset = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0; req = 2'b11; lock = 2'b10;
    run = 0; seen0 = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      check($sformatf("onehot[%0d]", c), 32'($onehot0(gnt)), 32'd1);
      if (gnt == 2'b10) run++; else run = 0;
      if (gnt == 2'b01) seen0++;
      check($sformatf("burst_len[%0d]", c), 32'(run <= MAX_BURST), 32'd1);
      @(posedge clk); #1;
    end
    check("req0_served", 32'(seen0), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
